lambda_peak_ctrl: RTL

//  Frame sequencer and peak finder for the lambda = mag - rho*phi metric pipeline (minus).
//  - Accepts a frame of FRAME_LEN (mag, phi) samples over valid/ready and feeds them to minus.
//  - Applies one rho per frame and tracks each sample through the pipeline's fixed latency.
//  - Returns the index and value of the maximum lambda over the frame on an out_valid/out_ready handshake.

---
 rtl/lambda_peak_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lambda_peak_ctrl.sv
// Frame sequencer and peak finder around the lambda = mag - rho*phi pipeline.
// Feeds accepted samples to minus, tags them through its latency and keeps the max.
module lambda_peak_ctrl #(
   parameter int  FRAME_LEN = 256,
   parameter int  PIPE_LAT  = 6,
   localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       cfg_rho,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [13:0]      in_mag,
   input  logic [13:0]      in_phi,
   output logic [13:0]      pipe_mag,
   output logic [13:0]      pipe_phi,
   output logic [7:0]       pipe_rho,
   input  logic [13:0]      pipe_lambda,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] peak_idx,
   output logic [13:0]      peak_lambda
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        rho_q, rho_d;
   logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
   logic [PIPE_LAT-1:0] vld_q, vld_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [13:0]       best_lambda_q, best_lambda_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              acc;
   logic              res;
   logic              better;

   always_comb begin
      state_d       = state_q;
      rho_d         = rho_q;
      iss_cnt_d     = iss_cnt_q;
      res_cnt_d     = res_cnt_q;
      best_idx_d    = best_idx_q;
      best_lambda_d = best_lambda_q;
      out_valid_d   = out_valid_q;
      // in_ready_q is only ever high in RUN, so it alone qualifies an accept
      acc    = in_valid & in_ready_q & ~abort;
      res    = vld_q[PIPE_LAT-1];
      better = (res_cnt_q == '0) ||
               ($signed(pipe_lambda) > $signed(best_lambda_q));
      vld_d    = '0;
      vld_d[0] = acc;
      for (int i = 1; i < PIPE_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end

      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         vld_d       = '0;
         iss_cnt_d   = '0;
         res_cnt_d   = '0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  rho_d         = cfg_rho;
                  iss_cnt_d     = '0;
                  res_cnt_d     = '0;
                  best_idx_d    = '0;
                  best_lambda_d = '0;
                  state_d       = S_RUN;
               end
            end
            S_RUN, S_DRAIN: begin
               if (acc) begin
                  iss_cnt_d = iss_cnt_q + 1'b1;
                  if (iss_cnt_q == LAST) state_d = S_DRAIN;
               end
               if (res) begin
                  if (better) begin
                     best_idx_d    = res_cnt_q[IDX_W-1:0];
                     best_lambda_d = pipe_lambda;
                  end
                  res_cnt_d = res_cnt_q + 1'b1;
                  if ((state_q == S_DRAIN) && (res_cnt_q == LAST)) begin
                     state_d     = S_DONE;
                     out_valid_d = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      in_ready_d = (state_d == S_RUN) && (iss_cnt_d < FULL);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rho_q         <= '0;
         iss_cnt_q     <= '0;
         res_cnt_q     <= '0;
         vld_q         <= '0;
         best_idx_q    <= '0;
         best_lambda_q <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rho_q         <= rho_d;
         iss_cnt_q     <= iss_cnt_d;
         res_cnt_q     <= res_cnt_d;
         vld_q         <= vld_d;
         best_idx_q    <= best_idx_d;
         best_lambda_q <= best_lambda_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign pipe_mag    = in_mag;
   assign pipe_phi    = in_phi;
   assign pipe_rho    = rho_q;
   assign peak_idx    = best_idx_q;
   assign peak_lambda = best_lambda_q;

endmodule
